// File: rtl/conv_window_sequencer_if.sv
// Byte load port, command/status, result stream and max report of conv_window_sequencer.
// master is the host/consumer side, slave is the sequencer.
interface conv_window_sequencer_if;
   logic        load_valid;
   logic        load_sel;
   logic [7:0]  load_data;
   logic        load_ready;
   logic        start;
   logic        busy;
   logic        res_valid;
   logic        res_ready;
   logic [17:0] res_data;
   logic        res_last;
   logic        max_valid;
   logic [17:0] max_data;
   logic [5:0]  max_idx;

   modport master (
      output load_valid, load_sel, load_data, start, res_ready,
      input  load_ready, busy, res_valid, res_data, res_last, max_valid, max_data, max_idx
   );

   modport slave (
      input  load_valid, load_sel, load_data, start, res_ready,
      output load_ready, busy, res_valid, res_data, res_last, max_valid, max_data, max_idx
   );
endinterface

// File: rtl/conv_window_sequencer.sv
// Buffers an IMG_DIM x IMG_DIM image and a 2x2 kernel, then walks every stride-1 window on one
// shared 8x8 multiplier, streaming each window sum and tracking the largest one.
module conv_window_sequencer #(
   parameter int unsigned IMG_DIM = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   conv_window_sequencer_if.slave bus
);
   localparam int unsigned NumPix = IMG_DIM * IMG_DIM;
   localparam int unsigned NumWin = (IMG_DIM - 1) * (IMG_DIM - 1);
   localparam int unsigned PixW   = $clog2(NumPix);
   localparam int unsigned PosW   = $clog2(IMG_DIM);

   typedef enum logic [1:0] {StIdle, StRun, StOut} state_e;

   state_e state_q, state_d;

   logic [7:0]      pix_mem_q [NumPix];
   logic [7:0]      w_q [4];
   logic [PixW-1:0] pix_ptr_q, pix_ptr_d;
   logic [1:0]      w_ptr_q, w_ptr_d;
   logic            pix_we, w_we;

   logic [PosW-1:0] row_q, row_d;
   logic [PosW-1:0] col_q, col_d;
   logic [5:0]      win_idx_q, win_idx_d;
   logic [1:0]      k_q, k_d;
   logic [17:0]     acc_q, acc_d;
   logic [17:0]     max_data_q, max_data_d;
   logic [5:0]      max_idx_q, max_idx_d;
   logic            max_valid_q, max_valid_d;

   logic [PixW-1:0] base_addr, mac_addr;
   logic [7:0]      mac_pix, mac_w;
   logic [15:0]     prod;
   logic            last_win;

   // k[1] selects the lower row of the window, k[0] the right-hand column.
   always_comb begin
      base_addr = PixW'(row_q) * PixW'(IMG_DIM) + PixW'(col_q);
      mac_addr  = base_addr + (k_q[1] ? PixW'(IMG_DIM) : '0) + PixW'(k_q[0]);
      mac_pix   = pix_mem_q[mac_addr];
      mac_w     = w_q[k_q];
      prod      = 16'(mac_pix) * 16'(mac_w);
   end

   assign last_win = (win_idx_q == 6'(NumWin - 1));

   always_comb begin
      state_d     = state_q;
      pix_ptr_d   = pix_ptr_q;
      w_ptr_d     = w_ptr_q;
      pix_we      = 1'b0;
      w_we        = 1'b0;
      row_d       = row_q;
      col_d       = col_q;
      win_idx_d   = win_idx_q;
      k_d         = k_q;
      acc_d       = acc_q;
      max_data_d  = max_data_q;
      max_idx_d   = max_idx_q;
      max_valid_d = max_valid_q;

      unique case (state_q)
         StIdle: begin
            if (bus.load_valid) begin
               if (bus.load_sel) begin
                  w_we    = 1'b1;
                  w_ptr_d = w_ptr_q + 2'd1;
               end else begin
                  pix_we    = 1'b1;
                  pix_ptr_d = (pix_ptr_q == PixW'(NumPix - 1)) ? '0 : pix_ptr_q + PixW'(1);
               end
            end
            // A write in the start cycle still lands at the old pointer; only the pointers clear.
            if (bus.start) begin
               pix_ptr_d   = '0;
               w_ptr_d     = '0;
               row_d       = '0;
               col_d       = '0;
               win_idx_d   = '0;
               k_d         = '0;
               acc_d       = '0;
               max_data_d  = '0;
               max_idx_d   = '0;
               max_valid_d = 1'b0;
               state_d     = StRun;
            end
         end

         StRun: begin
            acc_d = acc_q + 18'(prod);
            k_d   = k_q + 2'd1;
            if (k_q == 2'd3) begin
               state_d = StOut;
               // Update on the edge into OUT so the max is observable with the first res_valid.
               if ((win_idx_q == '0) || (acc_d > max_data_q)) begin
                  max_data_d = acc_d;
                  max_idx_d  = win_idx_q;
               end
            end
         end

         StOut: begin
            if (bus.res_ready) begin
               if (last_win) begin
                  max_valid_d = 1'b1;
                  state_d     = StIdle;
               end else begin
                  acc_d     = '0;
                  k_d       = '0;
                  win_idx_d = win_idx_q + 6'd1;
                  if (col_q == PosW'(IMG_DIM - 2)) begin
                     col_d = '0;
                     row_d = row_q + PosW'(1);
                  end else begin
                     col_d = col_q + PosW'(1);
                  end
                  state_d = StRun;
               end
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_ptr_q   <= '0;
         w_ptr_q     <= '0;
         row_q       <= '0;
         col_q       <= '0;
         win_idx_q   <= '0;
         k_q         <= '0;
         acc_q       <= '0;
         max_data_q  <= '0;
         max_idx_q   <= '0;
         max_valid_q <= 1'b0;
      end else begin
         pix_ptr_q   <= pix_ptr_d;
         w_ptr_q     <= w_ptr_d;
         row_q       <= row_d;
         col_q       <= col_d;
         win_idx_q   <= win_idx_d;
         k_q         <= k_d;
         acc_q       <= acc_d;
         max_data_q  <= max_data_d;
         max_idx_q   <= max_idx_d;
         max_valid_q <= max_valid_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NumPix); i++) begin
            pix_mem_q[i] <= '0;
         end
      end else if (pix_we) begin
         pix_mem_q[pix_ptr_q] <= bus.load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            w_q[i] <= '0;
         end
      end else if (w_we) begin
         w_q[w_ptr_q] <= bus.load_data;
      end
   end

   assign bus.load_ready = (state_q == StIdle);
   assign bus.busy       = (state_q != StIdle);
   assign bus.res_valid  = (state_q == StOut);
   assign bus.res_data   = acc_q;
   assign bus.res_last   = (state_q == StOut) && last_win;
   assign bus.max_valid  = max_valid_q;
   assign bus.max_data   = max_data_q;
   assign bus.max_idx    = max_idx_q;
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Randomized self-checking bench for conv_window_sequencer against an arithmetic window model.
module tb_conv_window_sequencer;
   localparam int unsigned D  = 4;
   localparam int unsigned NW = (D - 1) * (D - 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   conv_window_sequencer_if bus ();

   conv_window_sequencer #(.IMG_DIM(D)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference storage: image, kernel and host write pointers.
   int img [D*D];
   int wt [4];
   int pptr;
   int wptr;
   int exp_sum [NW];

   task automatic model_reset();
      for (int i = 0; i < int'(D * D); i++) img[i] = 0;
      for (int i = 0; i < 4; i++) wt[i] = 0;
      pptr = 0;
      wptr = 0;
   endtask

   task automatic model_write(input bit sel, input int data);
      if (sel) begin
         wt[wptr] = data;
         wptr = (wptr + 1) % 4;
      end else begin
         img[pptr] = data;
         pptr = (pptr + 1) % int'(D * D);
      end
   endtask

   task automatic compute_expected();
      for (int r = 0; r < int'(D) - 1; r++) begin
         for (int c = 0; c < int'(D) - 1; c++) begin
            exp_sum[r * (int'(D) - 1) + c] = img[r * D + c] * wt[0] + img[r * D + c + 1] * wt[1]
                                           + img[(r + 1) * D + c] * wt[2]
                                           + img[(r + 1) * D + c + 1] * wt[3];
         end
      end
   endtask

   task automatic host_write(input bit sel, input int data);
      bus.load_valid = 1'b1;
      bus.load_sel   = sel;
      bus.load_data  = 8'(data);
      @(negedge clk);
      bus.load_valid = 1'b0;
      model_write(sel, data);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      model_reset();
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL %s load_ready got %0b want 1", tag, bus.load_ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy got %0b want 0", tag, bus.busy); end
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL %s res_valid got %0b want 0", tag, bus.res_valid); end
      checks++; if (bus.res_data !== 18'd0) begin errors++; $display("FAIL %s res_data got %0d want 0", tag, bus.res_data); end
      checks++; if (bus.res_last !== 1'b0) begin errors++; $display("FAIL %s res_last got %0b want 0", tag, bus.res_last); end
      checks++; if (bus.max_valid !== 1'b0) begin errors++; $display("FAIL %s max_valid got %0b want 0", tag, bus.max_valid); end
      checks++; if (bus.max_data !== 18'd0) begin errors++; $display("FAIL %s max_data got %0d want 0", tag, bus.max_data); end
      checks++; if (bus.max_idx !== 6'd0) begin errors++; $display("FAIL %s max_idx got %0d want 0", tag, bus.max_idx); end
   endtask

   // Issues start (optionally with a coincident write), then follows the whole pass.
   task automatic run_pass(input string tag, input int hold_win, input int hold_len,
                           input int abort_win, input bit co_load, input bit co_sel,
                           input int co_data, input bit repulse);
      int  cyc, idx, hs_cyc, held, exp_max, exp_idx, limit;
      bit  seen, ready;
      if (co_load) model_write(co_sel, co_data);
      pptr = 0;
      wptr = 0;
      compute_expected();
      bus.start      = 1'b1;
      bus.load_valid = co_load;
      bus.load_sel   = co_sel;
      bus.load_data  = 8'(co_data);
      bus.res_ready  = 1'b0;
      @(negedge clk);
      bus.start      = 1'b0;
      bus.load_valid = 1'b0;
      cyc = 1; idx = 0; hs_cyc = 0; held = 0; seen = 1'b0; exp_max = 0; exp_idx = 0;
      limit = 6 * int'(NW) + hold_len + 50;
      while (idx < int'(NW) && cyc < limit) begin
         if (idx == abort_win && cyc == hs_cyc + 2) begin
            rst_n = 1'b0;
            bus.start = 1'b0;
            bus.res_ready = 1'b0;
            #1;
            check_reset_outputs({tag, "_abort"});
            model_reset();
            return;
         end
         if (bus.res_valid === 1'b1) begin
            if (!seen) begin
               seen = 1'b1;
               checks++;
               if (cyc != hs_cyc + 5) begin
                  errors++;
                  $display("FAIL %s cadence win %0d got cycle %0d want %0d", tag, idx, cyc, hs_cyc + 5);
               end
               checks++;
               if (bus.max_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL %s max_valid_mid win %0d got %0b want 0", tag, idx, bus.max_valid);
               end
               if (idx == 0 || exp_sum[idx] > exp_max) begin
                  exp_max = exp_sum[idx];
                  exp_idx = idx;
               end
            end
            checks++;
            if (bus.res_data !== 18'(exp_sum[idx])) begin
               errors++;
               $display("FAIL %s res_data win %0d got %0d want %0d", tag, idx, bus.res_data, exp_sum[idx]);
            end
            checks++;
            if (bus.res_last !== (idx == int'(NW) - 1)) begin
               errors++;
               $display("FAIL %s res_last win %0d got %0b want %0b", tag, idx, bus.res_last, idx == int'(NW) - 1);
            end
            checks++;
            if (bus.max_data !== 18'(exp_max)) begin
               errors++;
               $display("FAIL %s max_data win %0d got %0d want %0d", tag, idx, bus.max_data, exp_max);
            end
            checks++;
            if (bus.max_idx !== 6'(exp_idx)) begin
               errors++;
               $display("FAIL %s max_idx win %0d got %0d want %0d", tag, idx, bus.max_idx, exp_idx);
            end
            ready = !(idx == hold_win && held < hold_len);
            if (!ready) held++;
            bus.res_ready  = ready;
            bus.load_valid = !ready;
            bus.load_sel   = 1'($urandom);
            bus.load_data  = 8'($urandom);
            if (ready) begin
               hs_cyc = cyc;
               idx++;
               seen = 1'b0;
            end
         end else begin
            checks++;
            if (bus.busy !== 1'b1) begin
               errors++;
               $display("FAIL %s busy_run cycle %0d got %0b want 1", tag, cyc, bus.busy);
            end
            bus.res_ready  = 1'($urandom);
            bus.load_valid = 1'b0;
         end
         bus.start = repulse && (cyc % 3 == 0);
         @(negedge clk);
         cyc++;
      end
      bus.start      = 1'b0;
      bus.res_ready  = 1'b0;
      bus.load_valid = 1'b0;
      checks++;
      if (idx < int'(NW)) begin
         errors++;
         $display("FAIL %s timeout got %0d windows want %0d", tag, idx, NW);
      end else begin
         checks++; if (bus.max_valid !== 1'b1) begin errors++; $display("FAIL %s max_valid_end got %0b want 1", tag, bus.max_valid); end
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy_end got %0b want 0", tag, bus.busy); end
         checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL %s load_ready_end got %0b want 1", tag, bus.load_ready); end
         checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL %s res_valid_end got %0b want 0", tag, bus.res_valid); end
         checks++; if (bus.max_data !== 18'(exp_max)) begin errors++; $display("FAIL %s max_data_end got %0d want %0d", tag, bus.max_data, exp_max); end
         checks++; if (bus.max_idx !== 6'(exp_idx)) begin errors++; $display("FAIL %s max_idx_end got %0d want %0d", tag, bus.max_idx, exp_idx); end
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_reset_outputs("reset");
   endtask

   task automatic test_all_ones();
      do_reset();
      for (int i = 0; i < int'(D * D); i++) host_write(1'b0, 1);
      for (int i = 0; i < 4; i++) host_write(1'b1, 1);
      run_pass("ones", -1, 0, -1, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_ramp();
      do_reset();
      for (int i = 0; i < int'(D * D); i++) host_write(1'b0, i);
      host_write(1'b1, 1);
      for (int i = 0; i < 3; i++) host_write(1'b1, 0);
      run_pass("ramp", -1, 0, -1, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_full_scale();
      do_reset();
      for (int i = 0; i < int'(D * D); i++) host_write(1'b0, 255);
      for (int i = 0; i < 4; i++) host_write(1'b1, 255);
      run_pass("full", -1, 0, -1, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_random();
      do_reset();
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < int'(D * D); i++) host_write(1'b0, int'($urandom_range(0, 255)));
         for (int i = 0; i < 4; i++) host_write(1'b1, int'($urandom_range(0, 255)));
         run_pass("random", -1, 0, -1, 1'b0, 1'b0, 0, 1'b0);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < int'(D * D); i++) host_write(1'b0, int'($urandom_range(0, 255)));
      for (int i = 0; i < 4; i++) host_write(1'b1, int'($urandom_range(1, 255)));
      run_pass("backpressure", 3, 10, -1, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_reset_mid_pass();
      do_reset();
      for (int i = 0; i < int'(D * D); i++) host_write(1'b0, 255);
      for (int i = 0; i < 4; i++) host_write(1'b1, 255);
      run_pass("abort", -1, 0, 4, 1'b0, 1'b0, 0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet cycle %0d got valid %0b busy %0b want 0 0", i, bus.res_valid, bus.busy);
         end
      end
      for (int i = 0; i < int'(D * D); i++) host_write(1'b0, int'($urandom_range(0, 20)));
      for (int i = 0; i < 4; i++) host_write(1'b1, int'($urandom_range(0, 20)));
      run_pass("after_abort", -1, 0, -1, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_wrap_and_start();
      do_reset();
      for (int i = 0; i < int'(D * D); i++) host_write(1'b0, int'($urandom_range(10, 200)));
      host_write(1'b0, 9);
      host_write(1'b1, 1);
      for (int i = 0; i < 3; i++) host_write(1'b1, 0);
      // Weight pointer has wrapped to w0, so the coincident write replaces w0 with 3.
      run_pass("wrap_start", -1, 0, -1, 1'b1, 1'b1, 3, 1'b1);
   endtask

   initial begin
      bus.load_valid = 1'b0;
      bus.load_sel   = 1'b0;
      bus.load_data  = 8'd0;
      bus.start      = 1'b0;
      bus.res_ready  = 1'b0;
      test_reset();
      test_all_ones();
      test_ramp();
      test_full_scale();
      test_random();
      test_backpressure();
      test_reset_mid_pass();
      test_wrap_and_start();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Sequencer that owns a shared 2x2 convolution multiply-accumulate datapath. It buffers one IMG_DIM×IMG_DIM unsigned 8-bit image and one 2x2 weight kernel, both loaded byte-serially. On command it walks every stride-1 2x2 window, doing one product per cycle on a single time-shared 8×8 multiplier. Each window sum is streamed out over a valid/ready port, and the running maximum and its window index are tracked. It sits between the host byte interface and downstream result consumers, and replaces free-running convolution with a scheduled, back-pressurable pass.

## Interface
- IMG_DIM, 4, image side length; legal range 2..8; window count N = (IMG_DIM-1)^2
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  byte write strobe
- load_sel  in  1  0 = pixel byte, 1 = weight byte
- load_data  in  8  unsigned byte
- load_ready  out  1  high only in IDLE; writes accepted on load_valid & load_ready
- start  in  1  begin a pass; honoured only in IDLE
- busy  out  1  high in RUN and OUT
- res_valid  out  1  window result available
- res_ready  in  1  consumer accepts result
- res_data  out  18  window sum
- res_last  out  1  high with the final window's result (index N-1)
- max_valid  out  1  high from pass completion until the next accepted start
- max_data  out  18  largest window sum of the last pass
- max_idx  out  6  row-major window index (r*(IMG_DIM-1)+c) of that maximum

## Operation
- States:
  - IDLE: loads and start allowed.
  - RUN: 4 MAC cycles, k = 0..3.
  - OUT: result presented.
- Storage:
  - Pixel RAM of IMG_DIM² bytes (flops), written row-major at pix_ptr; pix_ptr increments per pixel write and wraps at IMG_DIM²-1 → 0.
  - Weight regs w0..w3 (w0 top-left, w1 top-right, w2 bottom-left, w3 bottom-right), written at w_ptr; w_ptr wraps 3 → 0.
- start accepted (IDLE & start):
  - Clear pix_ptr, w_ptr, window index, accumulator and max_data/max_idx.
  - Drop max_valid.
  - Go to RUN at window (0,0).
  - The next load therefore begins at index 0.
- RUN, step k:
  - acc += pixel × w_k. k0 uses (r,c), k1 uses (r,c+1), k2 uses (r+1,c), k3 uses (r+1,c+1).
  - After k3, go to OUT.
- OUT:
  - Hold res_valid with res_data = acc.
  - On entry, update the maximum if acc > max_data (strict). Ties keep the earlier index. Window 0 always loads its sum and index.
  - On res_valid & res_ready: if the window is not the last, advance c (and r on row end), clear acc and go to RUN; if it is the last, go to IDLE and set max_valid.
- Arithmetic: unsigned only.
  - Products are 16 bits.
  - 18-bit accumulator, exact; max 4×65025 = 260100.
  - No saturation needed.
- Ignored inputs:
  - load_valid outside IDLE has no effect; pointers and storage are unchanged.
  - start outside IDLE has no effect.
- Simultaneous load and start in IDLE: the write commits and the pointers clear. The byte is visible to the first MAC cycle.

## Timing
- Reset (async assert, sync use after deassert):
  - State IDLE, pointers 0, pixel RAM and weights 0, acc 0.
  - Outputs: load_ready=1, busy=0, res_valid=0, res_data=0, res_last=0, max_valid=0, max_data=0, max_idx=0.
- Result latency: start sampled at edge T → RUN T+1..T+4 → res_valid high from T+5.
- Window cadence: handshake at edge H → next res_valid at H+5. Minimum 5 cycles per window; 5N cycles per pass with res_ready held high.
- res_data, res_last and res_valid are stable while res_valid=1 and res_ready=0.
- max_data/max_idx update in the first OUT cycle of each window and are observable with that res_valid. max_valid rises the cycle after the final handshake.
- Reset mid-pass aborts immediately and returns to IDLE with no further res_valid.

## Test plan
- IMG_DIM=4, all pixels 1, weights 1,1,1,1, res_ready=1 → 9 results of 4; res_last on the 9th; max 4 / idx 0; results 5 cycles apart.
- Pixels 0..15 row-major, weights 1,0,0,0 → results 0,1,2,4,5,6,8,9,10; max_data 10, max_idx 8.
- All pixels and weights 255 → every res_data = 260100 with no wrap; max 260100 / idx 0.
- Backpressure: hold res_ready low 10 cycles on window 3 → res_data held constant, no window skipped or duplicated, and load_valid pulses during the hold leave storage unchanged.
- Assert rst_n low during RUN of window 4, then reload and start → outputs at reset values, the new pass starts at window 0 with correct sums, and max is not polluted by the aborted pass.
- Write 17 pixel bytes (value 9 last) → pix_ptr wraps and pixel (0,0) becomes 9; start with load_valid in the same cycle takes effect; start pulsed again while busy is ignored.
